// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module   : mod_counter_pkg
// Brief    : Shared mode and state encodings for mod_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mod_counter_tick_divider.sv
// ============================================================================
// Module   : tick_divider
// Brief    : Prescaler producing one tick every presc+1 enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_divider #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign tick = en && (r_cnt == presc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (sync_clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module   : mod_counter
// Brief    : Programmable up/down counter with prescaler, modulo top and
//            WRAP / SAT / ONESHOT terminal modes. Optional compare output is
//            built when MOD_COUNTER_CMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   top,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               wrap,
  output logic               running
`ifdef MOD_COUNTER_CMP_EN
  ,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic               cmp_match
`endif
);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_tick;
  logic             w_terminal;

  tick_divider #(
    .PRESC_W (PRESC_W)
  ) u_tick_divider (
    .clk      (clk),
    .rst      (rst),
    .en       (en && (r_state == ST_RUN)),
    .sync_clr (clear || load),
    .presc    (presc),
    .tick     (w_tick)
  );

  // Up direction uses >= so a count left above top by load/top change ends next tick.
  assign w_terminal = dir ? (r_count >= top) : (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
      w_state_nxt = ST_RUN;
    end else if (load) begin
      w_count_nxt = load_val;
      w_state_nxt = ST_RUN;
    end else if (w_tick) begin
      if (w_terminal) begin
        case (mode_e'(mode))
          MODE_SAT: begin
            w_count_nxt = r_count;
          end
          MODE_ONESHOT: begin
            w_wrap_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end
          default: begin
            w_count_nxt = dir ? '0 : top;
            w_wrap_nxt  = 1'b1;
          end
        endcase
      end else begin
        w_count_nxt = dir ? (r_count + 1'b1) : (r_count - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign running = (r_state == ST_RUN);

`ifdef MOD_COUNTER_CMP_EN
  logic r_cmp_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmp_match <= 1'b0;
    end else begin
      r_cmp_match <= (w_count_nxt == cmp_val);
    end
  end

  assign cmp_match = r_cmp_match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module   : tb_mod_counter
// Brief    : Self-checking bench for mod_counter (WIDTH=8, PRESC_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

  typedef struct {
    logic       en;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] top;
    logic [7:0] presc;
    logic [7:0] exp_count;
    logic       exp_wrap;
    logic       exp_run;
    logic       exp_cmp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clear, load, dir;
  logic [7:0] load_val, top, presc;
  logic [1:0] mode;
  logic [7:0] count;
  logic       wrap, running;
  logic [7:0] cmp_val = 8'd3;
`ifdef MOD_COUNTER_CMP_EN
  logic       cmp_match;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH   (8),
    .PRESC_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .dir       (dir),
    .mode      (mode),
    .top       (top),
    .presc     (presc),
    .count     (count),
    .wrap      (wrap),
    .running   (running)
`ifdef MOD_COUNTER_CMP_EN
    ,
    .cmp_val   (cmp_val),
    .cmp_match (cmp_match)
`endif
  );

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic c, input logic l, input logic [7:0] lv,
                              input logic d, input logic [1:0] m, input logic [7:0] t,
                              input logic [7:0] p, input logic [7:0] ec, input logic ew,
                              input logic er);
    vec_t v;
    v.en = e; v.clear = c; v.load = l; v.load_val = lv; v.dir = d; v.mode = m;
    v.top = t; v.presc = p; v.exp_count = ec; v.exp_wrap = ew; v.exp_run = er;
    v.exp_cmp = (ec == 8'd3);
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    en = v.en; clear = v.clear; load = v.load; load_val = v.load_val;
    dir = v.dir; mode = v.mode; top = v.top; presc = v.presc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("count", idx, int'(count), int'(e.exp_count));
    check("wrap", idx, int'(wrap), int'(e.exp_wrap));
    check("running", idx, int'(running), int'(e.exp_run));
`ifdef MOD_COUNTER_CMP_EN
    check("cmp_match", idx, int'(cmp_match), int'(e.exp_cmp));
`endif
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b1; mode = 2'd0; top = 8'd4; presc = '0;

    // up WRAP top=4
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   2,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   3,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   4,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   0,1,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   2,0,1));
    tbl.push_back(mk(0,0,0,  0,1,0,4,0,   2,0,1));
    tbl.push_back(mk(0,0,0,  0,1,0,4,0,   2,0,1));
    tbl.push_back(mk(1,1,0,  0,1,0,4,0,   0,0,1));
    // down WRAP top=3 from load 1
    tbl.push_back(mk(1,0,1,  1,0,0,3,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,0,0,3,0,   0,0,1));
    tbl.push_back(mk(1,0,0,  0,0,0,3,0,   3,1,1));
    tbl.push_back(mk(1,0,0,  0,0,0,3,0,   2,0,1));
    tbl.push_back(mk(1,0,0,  0,0,0,3,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,0,0,3,0,   0,0,1));
    tbl.push_back(mk(1,0,0,  0,0,0,3,0,   3,1,1));
    // SAT up top=255, then clear+load together
    tbl.push_back(mk(1,0,1,253,1,1,255,0, 253,0,1));
    tbl.push_back(mk(1,0,0,  0,1,1,255,0, 254,0,1));
    tbl.push_back(mk(1,0,0,  0,1,1,255,0, 255,0,1));
    tbl.push_back(mk(1,0,0,  0,1,1,255,0, 255,0,1));
    tbl.push_back(mk(1,0,0,  0,1,1,255,0, 255,0,1));
    tbl.push_back(mk(1,1,1,  7,1,1,255,0, 0,0,1));
    // load / clear win over a terminal tick
    tbl.push_back(mk(1,0,1,  2,1,0,2,0,   2,0,1));
    tbl.push_back(mk(1,0,1,  1,1,0,2,0,   1,0,1));
    tbl.push_back(mk(1,0,1,  2,1,0,2,0,   2,0,1));
    tbl.push_back(mk(1,1,0,  0,1,0,2,0,   0,0,1));
    // mode 3 acts as WRAP
    tbl.push_back(mk(1,0,1,  1,1,3,1,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,1,3,1,0,   0,1,1));
    tbl.push_back(mk(1,0,0,  0,1,3,1,0,   1,0,1));
    // top=0 up and down
    tbl.push_back(mk(1,1,0,  0,1,0,0,0,   0,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,0,0,   0,1,1));
    tbl.push_back(mk(1,0,0,  0,1,0,0,0,   0,1,1));
    tbl.push_back(mk(1,0,0,  0,0,0,0,0,   0,1,1));
    // count above top after load
    tbl.push_back(mk(1,0,1, 10,1,0,4,0,  10,0,1));
    tbl.push_back(mk(1,0,0,  0,1,0,4,0,   0,1,1));
    // ONESHOT up top=2, restart by load 0
    tbl.push_back(mk(1,1,0,  0,1,2,2,0,   0,0,1));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   2,0,1));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   2,1,0));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   2,0,0));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   2,0,0));
    tbl.push_back(mk(1,0,1,  0,1,2,2,0,   0,0,1));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   1,0,1));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   2,0,1));
    tbl.push_back(mk(1,0,0,  0,1,2,2,0,   2,1,0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 0, int'(count), 0);
    check("rst_wrap", 0, int'(wrap), 0);
    check("rst_running", 0, int'(running), 1);
`ifdef MOD_COUNTER_CMP_EN
    check("rst_cmp", 0, int'(cmp_match), 0);
`endif
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset mid-cycle from DONE with wrap high
    #3;
    rst = 1'b0;
    #1;
    check("async_count", 0, int'(count), 0);
    check("async_wrap", 0, int'(wrap), 0);
    check("async_running", 0, int'(running), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // presc=2: tick every 3rd enabled cycle, phase frozen while en low
    apply(mk(1,1,0,0,1,0,200,2, 0,0,1), 100);
    apply(mk(1,0,0,0,1,0,200,2, 0,0,1), 101);
    apply(mk(1,0,0,0,1,0,200,2, 0,0,1), 102);
    apply(mk(1,0,0,0,1,0,200,2, 1,0,1), 103);
    apply(mk(1,0,0,0,1,0,200,2, 1,0,1), 104);
    for (int k = 0; k < 5; k++) apply(mk(0,0,0,0,1,0,200,2, 1,0,1), 105 + k);
    apply(mk(1,0,0,0,1,0,200,2, 1,0,1), 110);
    apply(mk(1,0,0,0,1,0,200,2, 2,0,1), 111);
    apply(mk(1,0,0,0,1,0,200,2, 2,0,1), 112);
    apply(mk(1,0,0,0,1,0,200,2, 2,0,1), 113);
    apply(mk(1,0,0,0,1,0,200,2, 3,0,1), 114);

    // top=5 period with compare value 3
    apply(mk(1,1,0,0,1,0,5,0, 0,0,1), 200);
    for (int k = 1; k <= 13; k++) begin
      apply(mk(1,0,0,0,1,0,5,0, 8'(k % 6), (k % 6) == 0, 1), 200 + k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised programmable counter for general timing in the design: frame/line timers, timeouts, periodic strobes. Generalises the free-running 32-bit counter with configurable width, prescaler, modulo top value, up/down direction, three terminal-count modes and synchronous load/clear. Drives single-cycle terminal-count pulses to downstream control logic.

## Interface

- WIDTH, 32, counter width in bits (≥2)
- PRESC_W, 8, prescaler divisor width in bits (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; prescaler and counter freeze when low
- clear  in  1  synchronous clear
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value
- dir  in  1  1 = up, 0 = down
- mode  in  2  terminal mode (WRAP / SAT / ONESHOT)
- top  in  WIDTH  modulo top value
- presc  in  PRESC_W  divide ratio = presc+1
- count  out  WIDTH  current count
- wrap  out  1  terminal-count pulse
- running  out  1  high in RUN state
- cmp_val  in  WIDTH  compare value (only with MOD_COUNTER_CMP_EN)
- cmp_match  out  1  count == cmp_val (only with MOD_COUNTER_CMP_EN)

## Operation

- Priority per cycle: clear > load > step.
- clear: count←0, prescaler←0, state←RUN.
- load: count←load_val, prescaler←0, state←RUN.
- Prescaler: advances when en && state==RUN; emits tick and returns to 0 when equal to presc. presc=0 → tick every enabled cycle.
- Step on tick. Terminal condition: up → count ≥ top; down → count == 0.
- Non-terminal step: count ± 1, modulo 2^WIDTH never reached since terminal check precedes it.
- Terminal step by mode:
  - WRAP (0): count←0 (up) or top (down); wrap=1.
  - SAT (1): count holds; wrap=0.
  - ONESHOT (2): count holds; wrap=1; state←DONE.
  - mode 3: treated as WRAP.
- FSM: RUN ↔ DONE. DONE→RUN only via clear or load. In DONE, en and ticks ignored.
- top=0: up counts terminal every tick; down reloads 0.
- count > top after load or top change, up: next tick is terminal.
- dir/mode/top/presc changes take effect on next cycle; no internal state reset.

## Timing

- Reset values: count=0, wrap=0, running=1 (state RUN), prescaler=0, cmp_match=0.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- count registered: updates the edge after the tick cycle; with presc=0, en high, count increments every cycle.
- wrap registered, high exactly one cycle, coincident with count showing the reload/held value.
- running combinational from state register.
- clear/load in the same cycle as a terminal tick: clear/load win, wrap=0.
- en low: count, prescaler, wrap=0 hold; no tick lost or generated.

## Configuration

- MOD_COUNTER_CMP_EN defined: cmp_val/cmp_match ports exist; cmp_match registered from next-count value, so it is high exactly in cycles where count == cmp_val (including after load/clear).
- Not defined: ports and compare logic absent; all other behaviour identical.

## Structure

- Package mod_counter_pkg: mode enum (MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_ONESHOT=2'd2), state enum (ST_RUN, ST_DONE).
- One sub-module: tick_divider (PRESC_W, clk, rst, en, sync_clr, presc → tick).

## Test plan

- Reset, WIDTH=8, top=4, presc=0, up, WRAP, en=1 → count 0,1,2,3,4,0,…; wrap high on cycle count returns to 0.
- presc=2, same setup → count increments every 3rd enabled cycle; en low 5 cycles mid-run → count and phase unchanged.
- Down, WRAP, top=3, load_val=1 → 1,0,3,2,…; wrap high when count shows 3.
- ONESHOT, up, top=2 → 0,1,2 then holds 2, wrap one pulse, running=0; load load_val=0 → running=1, counting resumes.
- SAT, up, top=255 with WIDTH=8 → holds 255, wrap never asserts; clear and load asserted together → count=0.
- MOD_COUNTER_CMP_EN, cmp_val=3, top=5 → cmp_match high exactly while count==3 each period; rst low mid-count → all outputs reset immediately.
